// File: rtl/sync_fifo.sv
// Parametrised synchronous FIFO: a circular buffer with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] rear,
    input  logic             pop,
    output logic [WIDTH-1:0] front,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             acc_push;
    logic             acc_pop;
    logic             rej_push;
    logic             rej_pop;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // A push into a full FIFO is legal only when the same cycle frees a slot.
    assign acc_push = push & (~full | pop);
    assign acc_pop  = pop & ~empty;
    assign rej_push = push & ~acc_push;
    assign rej_pop  = pop & ~acc_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (acc_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (acc_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(acc_push) - CW'(acc_pop);
            if (rej_push) begin
                overflow <= 1'b1;
            end
            if (rej_pop) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && !flush && acc_push) begin
            mem[wr_ptr] <= rear;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));
    assign front        = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: table vectors, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, push, pop;
    logic [31:0] rear;
    logic [31:0] front;
    logic        empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;

    logic        push5, pop5;
    logic [7:0]  rear5, front5;
    logic        empty5, full5, af5, ae5, ovf5, udf5;
    logic [2:0]  count5;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [31:0] q8[$];
    logic        m_ovf, m_udf;
    logic [7:0]  q5[$];

    always #5 clk = ~clk;

    sync_fifo u_dut8 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .rear(rear), .pop(pop),
        .front(front), .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
        .clk(clk), .rst(rst), .flush(1'b0), .push(push5), .rear(rear5), .pop(pop5),
        .front(front5), .empty(empty5), .full(full5), .almost_full(af5),
        .almost_empty(ae5), .count(count5), .overflow(ovf5), .underflow(udf5)
    );

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] data;
        logic [3:0]  exp_count;
        logic [31:0] exp_front;
        logic        exp_full;
        logic        exp_af;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference behaviour: queue semantics, pop considered before push in the same cycle.
    function automatic void model_step(input logic f, input logic p, input logic o,
                                       input logic [31:0] d);
        bit was_full, was_empty, do_pop, do_push;
        if (f) begin
            q8.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        was_full  = (q8.size() == 8);
        was_empty = (q8.size() == 0);
        do_pop    = o && !was_empty;
        do_push   = p && (!was_full || o);
        if (o && !do_pop)  m_udf = 1'b1;
        if (p && !do_push) m_ovf = 1'b1;
        if (do_pop)  void'(q8.pop_front());
        if (do_push) q8.push_back(d);
    endfunction

    task automatic check8(input string tag);
        logic [31:0] ef;
        int n;
        n  = q8.size();
        ef = (n > 0) ? q8[0] : 32'h0;
        chk({tag, ".front"}, front, ef);
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 7));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic apply(input logic f, input logic p, input logic o, input logic [31:0] d);
        flush = f; push = p; pop = o; rear = d;
        @(posedge clk);
        model_step(f, p, o, d);
        @(negedge clk);
        flush = 1'b0; push = 1'b0; pop = 1'b0; rear = 32'h0;
    endtask

    task automatic step5(input logic p, input logic o, input logic [7:0] d);
        push5 = p; pop5 = o; rear5 = d;
        @(posedge clk);
        if (o && q5.size() > 0) void'(q5.pop_front());
        if (p && q5.size() < 5) q5.push_back(d);
        @(negedge clk);
        push5 = 1'b0; pop5 = 1'b0; rear5 = 8'h0;
    endtask

    initial begin
        // Reset-and-fill, overflow, drain and underflow, with values from the plan.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{push: 1'b1, pop: 1'b0, data: 32'h11 * (i + 1), exp_count: 4'(i + 1),
                       exp_front: 32'h11, exp_full: (i == 7), exp_af: (i >= 6),
                       exp_ovf: 1'b0, exp_udf: 1'b0};
        end
        tbl[8] = '{push: 1'b1, pop: 1'b0, data: 32'h99, exp_count: 4'd8, exp_front: 32'h11,
                   exp_full: 1'b1, exp_af: 1'b1, exp_ovf: 1'b1, exp_udf: 1'b0};
        for (int i = 0; i < 8; i++) begin
            tbl[9 + i] = '{push: 1'b0, pop: 1'b1, data: 32'h0, exp_count: 4'(7 - i),
                           exp_front: (i < 7) ? 32'h11 * (i + 2) : 32'h0, exp_full: 1'b0,
                           exp_af: (i == 0), exp_ovf: 1'b1, exp_udf: 1'b0};
        end
        tbl[17] = '{push: 1'b0, pop: 1'b1, data: 32'h0, exp_count: 4'd0, exp_front: 32'h0,
                    exp_full: 1'b0, exp_af: 1'b0, exp_ovf: 1'b1, exp_udf: 1'b1};

        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; rear = 32'h0;
        push5 = 1'b0; pop5 = 1'b0; rear5 = 8'h0;
        m_ovf = 1'b0; m_udf = 1'b0;
        repeat (2) @(negedge clk);
        check8("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            apply(1'b0, tbl[i].push, tbl[i].pop, tbl[i].data);
            chk({t, ".count"}, 32'(count), 32'(tbl[i].exp_count));
            chk({t, ".front"}, front, tbl[i].exp_front);
            chk({t, ".full"}, 32'(full), 32'(tbl[i].exp_full));
            chk({t, ".almost_full"}, 32'(almost_full), 32'(tbl[i].exp_af));
            chk({t, ".overflow"}, 32'(overflow), 32'(tbl[i].exp_ovf));
            chk({t, ".underflow"}, 32'(underflow), 32'(tbl[i].exp_udf));
        end

        // Push+pop while full: count holds, front advances, new entry drains last.
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 8; i++) apply(1'b0, 1'b1, 1'b0, 32'(i));
        apply(1'b0, 1'b1, 1'b1, 32'hAA);
        check8("full_pushpop");
        chk("full_pushpop.front_is_2", front, 32'h2);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("full_pushpop.last_is_aa", front, 32'hAA);
            apply(1'b0, 1'b0, 1'b1, 32'h0);
            check8($sformatf("drain%0d", i));
        end

        // Push+pop while empty: push lands, pop is rejected.
        apply(1'b0, 1'b1, 1'b1, 32'hBB);
        check8("empty_pushpop");
        chk("empty_pushpop.front", front, 32'hBB);
        chk("empty_pushpop.underflow", 32'(underflow), 32'h1);

        // Flush with count=5 and overflow set; the concurrent push is discarded.
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) apply(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, 32'h0);
        chk("preflush.count", 32'(count), 32'd5);
        chk("preflush.overflow", 32'(overflow), 32'h1);
        apply(1'b1, 1'b1, 1'b0, 32'hCC);
        check8("flush");
        chk("flush.count", 32'(count), 32'd0);
        chk("flush.front", front, 32'h0);

        // Asynchronous reset between edges with count=4.
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, 32'h200 + 32'(i));
        chk("prerst.count", 32'(count), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.count", 32'(count), 32'd0);
        chk("async_rst.front", front, 32'h0);
        chk("async_rst.empty", 32'(empty), 32'h1);
        q8.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q5.delete();
        apply(1'b0, 1'b1, 1'b0, 32'hDD);
        check8("post_rst_push");

        // Wrap-around on DEPTH=5 at steady occupancy 3.
        for (int i = 0; i < 3; i++) step5(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 23; i++) begin
            chk($sformatf("wrap%0d.front_before", i), 32'(front5), 32'(q5[0]));
            step5(1'b1, 1'b1, 8'(8'h40 + i));
            chk($sformatf("wrap%0d.count", i), 32'(count5), 32'd3);
            chk($sformatf("wrap%0d.front", i), 32'(front5), 32'(q5[0]));
        end

        // Randomized traffic on DEPTH=8 against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic f, p, o;
            f = ($urandom_range(39) == 0);
            p = ($urandom_range(99) < 60);
            o = ($urandom_range(99) < 50);
            apply(f, p, o, $urandom);
            check8($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO that generalises the pipeline's fixed-width shift-register queue into a pointer-based circular buffer. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It is intended for instruction-fetch buffering between the icache and IF, and for store buffering between MA and the dcache.

## Interface
- WIDTH, 32, data bits per entry (≥1)
- DEPTH, 8, number of entries (≥2, need not be a power of two)
- AF_LEVEL, DEPTH-1, almost_full asserted when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserted when count ≤ AE_LEVEL (0..DEPTH-1)
- CW (localparam), $clog2(DEPTH+1), width of count

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous clear of contents and error flags
- push  in  1  write request
- rear  in  WIDTH  write data, sampled when a push is accepted
- pop  in  1  read request; consumes the entry shown on front
- front  out  WIDTH  oldest entry; 0 when empty
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- Storage: DEPTH×WIDTH register array, not reset. Read pointer rd_ptr, write pointer wr_ptr, and count are registered.
- Pointers increment modulo DEPTH: DEPTH-1 wraps to 0. No reliance on power-of-two wrap.
- Accepted push (acc_push) = push & (~full | pop).
- Accepted pop (acc_pop) = pop & ~empty.
- A push while full is accepted only if a pop occurs in the same cycle. The write goes to wr_ptr, which equals the slot being freed.
- A push and pop while empty: push is accepted; pop is rejected and sets underflow. There is no bypass.
- On acc_push: mem[wr_ptr] ← rear, and wr_ptr advances.
- On acc_pop: rd_ptr advances.
- count next value = count + acc_push − acc_pop, so simultaneous push and pop leaves count unchanged.
- Rejected push: overflow ← 1. Rejected pop: underflow ← 1. Both flags stay set until rst or flush.
- front = empty ? 0 : mem[rd_ptr]. This is combinational from registered state; it does not depend on push or pop in the same cycle.
- All status flags are decoded combinationally from count only.
- Priority order is rst > flush > push/pop.
- flush resets pointers, count and both error flags to 0. Any push or pop in the flush cycle is ignored, and no error flag is set by it.
- rst mid-operation: all registered state clears immediately, regardless of clk. Contents are lost, and front reads 0 as soon as rst asserts.

## Timing
- Reset values: front=0, empty=1, full=0, almost_full=(AF_LEVEL==0 ? n/a : 0), almost_empty=1, count=0, overflow=0, underflow=0.
- Write-to-read latency is 1 cycle: data pushed at edge N appears on front after edge N if the FIFO was empty.
- A pop takes effect at the edge. The next entry, or 0 if the FIFO became empty, is presented after that edge.
- Flags and count update at the same edge as the pointers and carry no extra latency.
- Throughput is one push and one pop per cycle, sustained at any occupancy, including full and empty boundaries per the rules above.
- There are no combinational paths from push, pop or rear to any output.

## Test plan
- **Reset and fill:** reset, then push 0x11,0x22,…,0x88 on 8 consecutive cycles (DEPTH=8) → count steps 1..8; full=1 after the 8th edge; almost_full=1 from count=7; front=0x11 from the first edge on; overflow=0.
- **Overflow and drain:** with the FIFO full, push 0x99 alone → overflow=1 and count stays 8. Then pop 8 times → front sequence 0x11..0x88, then empty=1 and front=0. A 9th pop → underflow=1.
- **Wrap-around:** with DEPTH=5, run 23 push/pop cycles at steady occupancy 3 → output order matches input order, and count stays 3 throughout pointer wrap.
- **Simultaneous push/pop at boundaries:**
  - When full, push 0xAA with pop → count=8, front advances, 0xAA is read out last, overflow unchanged.
  - When empty, push 0xBB with pop → count=1, front=0xBB, underflow=1.
- **Flush:** with count=5 and overflow=1, assert flush together with push → next cycle count=0, empty=1, overflow=0, front=0, and the pushed data is discarded.
- **Async reset mid-stream:** assert rst between clock edges while count=4 → count=0 and front=0 before the next edge. After release, the first push is accepted normally.
